// File: rtl/s_link_pkg.sv
// Constants and state type shared by both ends of the RB1<->RB2 serial link.
package s_link_pkg;
  localparam int FWD_ADDR_W = 3;
  localparam int FWD_DATA_W = 18;
  localparam int FWD_GAP    = 1;
  localparam int FWD_FRAME  = FWD_ADDR_W + FWD_DATA_W + FWD_GAP;
  localparam int REV_ROW_W  = 5;
  localparam int REV_DATA_W = 8;
  localparam int REV_FRAME  = 14;
  localparam int ROWS       = 18;
  localparam int COLS       = 8;

  typedef enum logic [1:0] {TX, RX_WAIT, RX, DONE} link_state_t;
endpackage

// File: rtl/s_link_shift_rx.sv
// Reverse-frame receiver: 13 sampled bits (row then data, MSB first) plus one idle cycle.
module s_link_shift_rx
  import s_link_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  sd_in,
  output logic                  frame_valid,
  output logic                  frame_end,
  output logic [REV_ROW_W-1:0]  row,
  output logic [REV_DATA_W-1:0] data
);
  logic [3:0]            cnt;
  logic [REV_DATA_W-1:0] shreg;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt   <= '0;
      row   <= '0;
      shreg <= '0;
    end else begin
      cnt <= (cnt == 4'(REV_FRAME-1)) ? 4'd0 : cnt + 4'd1;
      if (cnt < 4'(REV_ROW_W))
        row <= {row[REV_ROW_W-2:0], sd_in};
      else if (cnt < 4'(REV_FRAME-1))
        shreg <= {shreg[REV_DATA_W-2:0], sd_in};
    end
  end

  // frame_valid marks the edge that samples the last data bit; data already includes it
  assign frame_valid = en && (cnt == 4'(REV_FRAME-2));
  assign frame_end   = en && (cnt == 4'(REV_FRAME-1));
  assign data        = {shreg[REV_DATA_W-2:0], sd_in};
endmodule

// File: rtl/s1_bank_link.sv
// S1 end of the link: sends RB1 transposed as 8 forward frames, then writes 18 reverse frames back.
module s1_bank_link
  import s_link_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       updown,
  input  logic       S2_done,
  output logic       S1_done,
  output logic       RB1_RW,
  output logic [4:0] RB1_A,
  output logic [7:0] RB1_D,
  input  logic [7:0] RB1_Q,
  inout  wire        sen,
  inout  wire        sd
);
  link_state_t           state;
  logic [2:0]            j;
  logic [4:0]            t;
  logic [4:0]            n;
  logic                  sd_val;
  logic                  rx_en;
  logic                  frame_valid;
  logic                  frame_end;
  logic [REV_ROW_W-1:0]  row;
  logic [REV_DATA_W-1:0] data;

  assign rx_en = (state == RX);

  s_link_shift_rx u_rx (
    .clk         (clk),
    .rst         (rst),
    .en          (rx_en),
    .sd_in       (sd),
    .frame_valid (frame_valid),
    .frame_end   (frame_end),
    .row         (row),
    .data        (data)
  );

  // Held at frame 0 addr MSB during reset so the peer's first sample is already right
  always_comb begin
    sd_val = 1'b0;
    if (state == TX) begin
      case (t)
        5'd0:                 sd_val = j[2];
        5'd1:                 sd_val = j[1];
        5'd2:                 sd_val = j[0];
        5'(FWD_FRAME-1):      sd_val = 1'b0;
        default:              sd_val = RB1_Q[j];
      endcase
    end
  end

  assign sd  = updown ? 1'bz : sd_val;
  assign sen = rst | (state != TX) | (t == 5'(FWD_FRAME-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= TX;
      j       <= '0;
      t       <= '0;
      n       <= '0;
      S1_done <= 1'b0;
      RB1_RW  <= 1'b1;
      RB1_A   <= '0;
      RB1_D   <= '0;
    end else begin
      case (state)
        TX: begin
          RB1_RW <= 1'b1;
          // address leads by one cycle so RB1_Q lines up with bit t = 3 + r
          RB1_A  <= (t >= 5'(FWD_ADDR_W-1) && t < 5'(FWD_ADDR_W+ROWS-1))
                    ? t - 5'(FWD_ADDR_W-1) : 5'd0;
          if (t == 5'(FWD_FRAME-1)) begin
            t <= '0;
            if (j == 3'(COLS-1)) begin
              j     <= '0;
              state <= RX_WAIT;
            end else begin
              j <= j + 3'd1;
            end
          end else begin
            t <= t + 5'd1;
          end
        end
        RX_WAIT: begin
          n <= '0;
          if (S2_done) state <= RX;
        end
        RX: begin
          if (frame_valid && row < 5'(ROWS)) begin
            RB1_RW <= 1'b0;
            RB1_A  <= row;
            RB1_D  <= data;
          end else begin
            RB1_RW <= 1'b1;
          end
          if (frame_end) begin
            if (n == 5'(ROWS-1)) begin
              state   <= DONE;
              S1_done <= 1'b1;
            end else begin
              n <= n + 5'd1;
            end
          end
        end
        DONE: begin
          S1_done <= 1'b1;
          RB1_RW  <= 1'b1;
        end
        default: state <= TX;
      endcase
    end
  end
endmodule
